// File: rtl/dfm_pkg.sv
// -----------------------------------------------------------------------------
// dfm_pkg
// Shared definitions for the digital-frequency-meter core: SPI opcodes,
// measurement FSM state encoding, counter width, default gate unit and a
// helper that clamps a requested gate time to a usable value.
// -----------------------------------------------------------------------------
package dfm_pkg;

   // Width of each of the reference and signal counters.
   localparam int CNT_W = 32;

   // clk_i cycles per gate_time LSB (1 ms at 200 MHz).
   localparam int GATE_UNIT_DEF = 200_000;

   // SPI command opcodes.
   localparam logic [7:0] CMD_CONF_WR = 8'h2A;
   localparam logic [7:0] CMD_MEAS_ST = 8'h2B;
   localparam logic [7:0] CMD_REG_RD  = 8'h3A;

   // Measurement engine states.
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_ARM  = 3'd1,
      ST_GATE = 3'd2,
      ST_WAIT = 3'd3,
      ST_DONE = 3'd4
   } meas_state_t;

   // A gate time of zero would end the gate immediately; treat it as one unit.
   function automatic logic [7:0] eff_gate_time(input logic [7:0] raw);
      logic [7:0] eff;
      if (raw == 8'd0) begin
         eff = 8'd1;
      end else begin
         eff = raw;
      end
      return eff;
   endfunction

endpackage

// File: rtl/dfm_measure.sv
// -----------------------------------------------------------------------------
// dfm_measure
// Reciprocal (equal-precision) frequency measurement engine. The gate opens on
// a rising edge of the measured signal and closes on the first rising edge
// after the gate timer expires, so both counters span a whole number of signal
// periods.
// Ports:
//   clk        in   1      system clock
//   rst        in   1      asynchronous active-high reset
//   gate_st    in   1      one-cycle start request
//   gate_time  in   8      gate length in GATE_UNIT clk cycles (never zero)
//   sig_clk    in   1      signal under measurement, asynchronous to clk
//   busy       out  1      registered, high in ARM, GATE and WAIT
//   done       out  1      high for the single DONE cycle
//   ref_cnt    out  CNT_W  clk cycles counted across the gate
//   sig_cnt    out  CNT_W  signal rising edges counted across the gate
// -----------------------------------------------------------------------------
module dfm_measure
   import dfm_pkg::*;
#(
   parameter int GATE_UNIT = GATE_UNIT_DEF,
   parameter int CNT_W_P   = CNT_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               gate_st,
   input  logic [7:0]         gate_time,
   input  logic               sig_clk,
   output logic               busy,
   output logic               done,
   output logic [CNT_W_P-1:0] ref_cnt,
   output logic [CNT_W_P-1:0] sig_cnt
);

   logic [2:0]         sync_r;
   logic               sig_rise_s;
   meas_state_t        state_r;
   meas_state_t        state_s;
   logic               enter_gate_s;
   logic [31:0]        timer_r;
   logic [31:0]        limit_s;
   logic               timer_hit_s;
   logic               busy_r;
   logic [CNT_W_P-1:0] ref_cnt_r;
   logic [CNT_W_P-1:0] sig_cnt_r;

   // Two-flop synchronizer plus one history flop for edge detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_r <= 3'b000;
      end else begin
         sync_r <= {sync_r[1:0], sig_clk};
      end
   end

   assign sig_rise_s  = sync_r[1] & ~sync_r[2];
   assign limit_s     = 32'(gate_time) * 32'(GATE_UNIT);
   // The gate lasts exactly limit_s clk cycles from GATE entry.
   assign timer_hit_s = ((timer_r + 32'd1) >= limit_s) ? 1'b1 : 1'b0;

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic. A start request re-arms from ARM or WAIT so a stalled
   // signal can be recovered; during GATE the running measurement is kept.
   always_comb begin
      state_s      = state_r;
      enter_gate_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (gate_st) begin
               state_s = ST_ARM;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_ARM: begin
            if (gate_st) begin
               state_s = ST_ARM;
            end else if (sig_rise_s) begin
               state_s      = ST_GATE;
               enter_gate_s = 1'b1;
            end else begin
               state_s = ST_ARM;
            end
         end
         ST_GATE: begin
            if (timer_hit_s) begin
               state_s = ST_WAIT;
            end else begin
               state_s = ST_GATE;
            end
         end
         ST_WAIT: begin
            if (gate_st) begin
               state_s = ST_ARM;
            end else if (sig_rise_s) begin
               state_s = ST_DONE;
            end else begin
               state_s = ST_WAIT;
            end
         end
         ST_DONE: begin
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // Busy is registered from the next state so it tracks state_r exactly.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_r <= 1'b0;
      end else begin
         busy_r <= ((state_s == ST_ARM) || (state_s == ST_GATE) ||
                    (state_s == ST_WAIT)) ? 1'b1 : 1'b0;
      end
   end

   // Counters and gate timer; the edge that ends WAIT is still counted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ref_cnt_r <= '0;
         sig_cnt_r <= '0;
         timer_r   <= 32'd0;
      end else if (enter_gate_s) begin
         ref_cnt_r <= '0;
         sig_cnt_r <= '0;
         timer_r   <= 32'd0;
      end else if ((state_r == ST_GATE) || (state_r == ST_WAIT)) begin
         ref_cnt_r <= ref_cnt_r + CNT_W_P'(1);
         if (sig_rise_s) begin
            sig_cnt_r <= sig_cnt_r + CNT_W_P'(1);
         end
         if (state_r == ST_GATE) begin
            timer_r <= timer_r + 32'd1;
         end
      end
   end

   assign busy    = busy_r;
   assign done    = (state_r == ST_DONE) ? 1'b1 : 1'b0;
   assign ref_cnt = ref_cnt_r;
   assign sig_cnt = sig_cnt_r;

endmodule

// File: rtl/dfm_core.sv
// -----------------------------------------------------------------------------
// dfm_core
// Frequency-meter core behind an SPI slave: decodes command/data bytes,
// launches reciprocal measurements, holds the 64-bit result and serves it
// back one byte per SPI transfer (LSB first).
// Ports:
//   clk_i            in   1   system clock
//   rst_i            in   1   asynchronous active-high reset
//   dc_i             in   1   0 = command byte, 1 = data byte
//   spi_byte_vld_i   in   1   one-cycle strobe for spi_byte_data_i
//   spi_byte_data_i  in   8   received byte
//   sig_clk_i        in   1   signal under measurement (asynchronous)
//   reg_rd_data_o    out  8   result byte selected by the read pointer
//   busy_o           out  1   measurement in progress
// -----------------------------------------------------------------------------
module dfm_core
   import dfm_pkg::*;
#(
   parameter int GATE_UNIT = GATE_UNIT_DEF
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       dc_i,
   input  logic       spi_byte_vld_i,
   input  logic [7:0] spi_byte_data_i,
   input  logic       sig_clk_i,
   output logic [7:0] reg_rd_data_o,
   output logic       busy_o
);

   logic             cmd_vld_s;
   logic             dat_vld_s;
   logic             is_conf_s;
   logic             is_meas_s;
   logic             is_rd_s;
   logic             known_cmd_s;
   logic             conf_pend_r;
   logic [7:0]       gate_time_r;
   logic             rd_mode_r;
   logic             rd_inc_r;
   logic [2:0]       rd_addr_r;
   logic             gate_st_r;
   logic [63:0]      result_r;
   logic             busy_s;
   logic             done_s;
   logic [CNT_W-1:0] ref_cnt_s;
   logic [CNT_W-1:0] sig_cnt_s;

   assign cmd_vld_s   = spi_byte_vld_i & ~dc_i;
   assign dat_vld_s   = spi_byte_vld_i & dc_i;
   assign is_conf_s   = (cmd_vld_s && (spi_byte_data_i == CMD_CONF_WR)) ? 1'b1 : 1'b0;
   assign is_meas_s   = (cmd_vld_s && (spi_byte_data_i == CMD_MEAS_ST)) ? 1'b1 : 1'b0;
   assign is_rd_s     = (cmd_vld_s && (spi_byte_data_i == CMD_REG_RD))  ? 1'b1 : 1'b0;
   // Unknown opcodes leave every mode flag untouched.
   assign known_cmd_s = is_conf_s | is_meas_s | is_rd_s;

   // CONF_WR accepts exactly one data byte as the new gate time.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         conf_pend_r <= 1'b0;
         gate_time_r <= 8'd1;
      end else if (is_conf_s) begin
         conf_pend_r <= 1'b1;
      end else if (known_cmd_s) begin
         conf_pend_r <= 1'b0;
      end else if (dat_vld_s && conf_pend_r) begin
         conf_pend_r <= 1'b0;
         gate_time_r <= eff_gate_time(spi_byte_data_i);
      end
   end

   // Read mode stays open until the next known command.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rd_mode_r <= 1'b0;
      end else if (is_rd_s) begin
         rd_mode_r <= 1'b1;
      end else if (known_cmd_s) begin
         rd_mode_r <= 1'b0;
      end
   end

   // Pointer advances one cycle after the data byte, after it was shifted out.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rd_inc_r  <= 1'b0;
         rd_addr_r <= 3'd0;
      end else begin
         rd_inc_r <= dat_vld_s & rd_mode_r;
         if (is_rd_s) begin
            rd_addr_r <= 3'd0;
         end else if (rd_inc_r) begin
            rd_addr_r <= rd_addr_r + 3'd1;
         end
      end
   end

   // One-cycle start pulse towards the measurement engine.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         gate_st_r <= 1'b0;
      end else begin
         gate_st_r <= is_meas_s;
      end
   end

   // Result register: reference count in the upper word, signal count below.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         result_r <= 64'h0;
      end else if (done_s) begin
         result_r <= 64'({ref_cnt_s, sig_cnt_s});
      end
   end

   dfm_measure #(
      .GATE_UNIT (GATE_UNIT),
      .CNT_W_P   (CNT_W)
   ) u_measure (
      .clk       (clk_i),
      .rst       (rst_i),
      .gate_st   (gate_st_r),
      .gate_time (gate_time_r),
      .sig_clk   (sig_clk_i),
      .busy      (busy_s),
      .done      (done_s),
      .ref_cnt   (ref_cnt_s),
      .sig_cnt   (sig_cnt_s)
   );

   assign reg_rd_data_o = result_r[{rd_addr_r, 3'b000} +: 8];
   assign busy_o        = busy_s;

endmodule

// File: tb/tb_dfm_core.sv
`timescale 1ns/1ps
module tb_dfm_core;

   logic       clk;
   logic       rst;
   logic       dc;
   logic       vld;
   logic [7:0] data;
   logic       sig_clk;
   logic       sig_en;
   logic [7:0] rd_data;
   logic       busy;

   int vectors;
   int miscompares;

   dfm_core #(.GATE_UNIT(10)) dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .dc_i            (dc),
      .spi_byte_vld_i  (vld),
      .spi_byte_data_i (data),
      .sig_clk_i       (sig_clk),
      .reg_rd_data_o   (rd_data),
      .busy_o          (busy)
   );

   // 5 ns system clock
   initial clk = 1'b0;
   always #2.5 clk = ~clk;

   // 500 ns measured signal, held low while disabled
   initial sig_clk = 1'b0;
   always #250 sig_clk = sig_en ? ~sig_clk : 1'b0;

   task automatic chk(input logic [63:0] obs, input logic [63:0] exp, input string tag);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic is_data, input logic [7:0] b);
      @(negedge clk);
      dc   = is_data;
      data = b;
      vld  = 1'b1;
      @(negedge clk);
      vld  = 1'b0;
      dc   = 1'b0;
      data = 8'h00;
   endtask

   // REG_RD then 9 data bytes; the 9th must show byte 0 again
   task automatic read_check(input logic [63:0] exp, input string tag);
      logic [63:0] e;
      e = exp;
      send(1'b0, 8'h3A);
      for (int i = 0; i < 9; i++) begin
         chk({56'd0, rd_data}, {56'd0, e[8*(i%8) +: 8]}, $sformatf("%s_b%0d", tag, i));
         send(1'b1, 8'h00);
         @(negedge clk);
      end
   endtask

   task automatic wait_idle(input int max_cyc, output int used);
      int n;
      n = 0;
      while ((busy === 1'b1) && (n < max_cyc)) begin
         @(negedge clk);
         n++;
      end
      used = n;
      chk({63'd0, busy}, 64'd0, "busy_timeout");
   endtask

   task automatic measure(input logic [63:0] exp, input string tag);
      int n;
      send(1'b0, 8'h2B);
      repeat (2) @(negedge clk);
      chk({63'd0, busy}, 64'd1, {tag, "_busy"});
      wait_idle(2000, n);
      repeat (3) @(negedge clk);
      read_check(exp, tag);
   endtask

   initial begin
      int n;
      vectors     = 0;
      miscompares = 0;
      rst    = 1'b1;
      dc     = 1'b0;
      vld    = 1'b0;
      data   = 8'h00;
      sig_en = 1'b0;
      repeat (4) @(negedge clk);
      chk({63'd0, busy}, 64'd0, "rst_busy");
      chk({56'd0, rd_data}, 64'd0, "rst_rd");
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // all-zero readback with pointer wrap
      read_check(64'h0, "rd_zero");

      // gate 2 units = 20 clk -> one period: ref 100, sig 1
      sig_en = 1'b1;
      send(1'b0, 8'h2A);
      send(1'b1, 8'h02);
      send(1'b0, 8'h2B);
      repeat (2) @(negedge clk);
      chk({63'd0, busy}, 64'd1, "m1_busy");
      wait_idle(2000, n);
      chk({63'd0, ((n >= 90) && (n <= 230)) ? 1'b1 : 1'b0}, 64'd1, "m1_busy_len");
      repeat (3) @(negedge clk);
      read_check(64'h00000064_00000001, "m1");

      // second MEAS_ST while busy does not disturb the measurement
      send(1'b0, 8'h2B);
      repeat (30) @(negedge clk);
      send(1'b0, 8'h2B);
      repeat (2) @(negedge clk);
      chk({63'd0, busy}, 64'd1, "m2_busy_again");
      wait_idle(2000, n);
      repeat (3) @(negedge clk);
      read_check(64'h00000064_00000001, "m2");

      // gate 12 units = 120 clk spans two periods; extra data byte ignored
      send(1'b0, 8'h2A);
      send(1'b1, 8'h0C);
      send(1'b1, 8'h01);
      measure(64'h000000C8_00000002, "m3");

      // unknown opcode: no busy, result and gate time unchanged
      send(1'b0, 8'h55);
      send(1'b1, 8'h02);
      repeat (2) @(negedge clk);
      chk({63'd0, busy}, 64'd0, "op55_busy");
      read_check(64'h000000C8_00000002, "op55");
      measure(64'h000000C8_00000002, "m4");

      // gate time 0 behaves as 1 unit
      send(1'b0, 8'h2A);
      send(1'b1, 8'h00);
      measure(64'h00000064_00000001, "m5");

      // stalled signal keeps the engine armed; re-arm then complete
      send(1'b0, 8'h2A);
      send(1'b1, 8'h0C);
      sig_en = 1'b0;
      repeat (300) @(negedge clk);
      send(1'b0, 8'h2B);
      repeat (300) @(negedge clk);
      chk({63'd0, busy}, 64'd1, "stall_busy");
      read_check(64'h00000064_00000001, "stall_rd");
      send(1'b0, 8'h2B);
      repeat (2) @(negedge clk);
      chk({63'd0, busy}, 64'd1, "rearm_busy");
      sig_en = 1'b1;
      wait_idle(2000, n);
      repeat (3) @(negedge clk);
      read_check(64'h000000C8_00000002, "rearm");

      // reset while in GATE aborts and clears the result asynchronously
      send(1'b0, 8'h2B);
      repeat (110) @(negedge clk);
      chk({63'd0, busy}, 64'd1, "gate_busy");
      #1 rst = 1'b1;
      #1;
      chk({63'd0, busy}, 64'd0, "arst_busy");
      chk({56'd0, rd_data}, 64'd0, "arst_rd");
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk({63'd0, busy}, 64'd0, "post_rst_busy");
      read_check(64'h0, "post_rst");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
